// File: rtl/mult32_seq.sv
// Sequential 32x32 -> 64-bit shift-add multiplier, one iteration per clock.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module mult32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [63:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        neg;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] sum;
  logic [63:0] acc_step;
  logic [63:0] result;

  // The carry out of the upper-half add becomes the new MSB after the shift,
  // so -2^31 x -2^31 (magnitudes 2^31) still lands exactly on 2^62.
  always_comb begin
    mag_a    = (sgn && a[31]) ? (~a + 32'd1) : a;
    mag_b    = (sgn && b[31]) ? (~b + 32'd1) : b;
    sum      = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    acc_step = {sum, acc[31:1]};
    result   = neg ? (~acc + 64'd1) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 6'd0;
      acc    <= 64'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      neg    <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= sgn & (a[31] ^ b[31]);
            acc    <= 64'd0;
            count  <= 6'd0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
          if (count == 6'd31) state <= FIN;
        end
        FIN: begin
          hi    <= result[63:32];
          lo    <= result[31:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: the driver queues arithmetic reference results,
// and a negedge monitor checks each DONE pulse, its timing, BUSY length and HI/LO hold.
module tb_mult32_seq;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  exp_t        qExp[$];
  int          cyc;
  int          total;
  int          bad;
  int          busyRun;
  bit          armed;
  logic [63:0] lastExp;

  mult32_seq dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] refProduct(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    if (s) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      return 64'(sp);
    end
    up = longint'({32'd0, x}) * longint'({32'd0, y});
    return 64'(up);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Drives one START at posedge+1; the accept edge is the next posedge,
  // so the result is due at the negedge of cycle cyc+34.
  task automatic applyStimulus(input logic s, input logic [31:0] x, input logic [31:0] y,
                               input bit useConst, input logic [63:0] constExp);
    exp_t e;
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    e.prod = useConst ? constExp : refProduct(s, x, y);
    e.due  = cyc + 34;
    qExp.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    sgn   = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (qExp.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_timeout", 64'(qExp.size()), 64'd0);
    qExp.delete();
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every DONE must match the oldest queued result at its due cycle.
  always @(negedge clk) begin
    if (armed && !rst) begin
      if (busy) busyRun++;
      if (done) begin
        if (qExp.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = qExp.pop_front();
          checkOutput("product", {hi, lo}, e.prod);
          checkOutput("done_cycle", 64'(cyc), 64'(e.due));
          checkOutput("busy_len", 64'(busyRun), 64'd33);
          lastExp = e.prod;
        end
        busyRun = 0;
      end else begin
        checkOutput("hold", {hi, lo}, lastExp);
      end
    end else if (rst) begin
      busyRun = 0;
    end
  end

  initial begin
    logic s;
    int   j;
    cyc     = 0;
    total   = 0;
    bad     = 0;
    busyRun = 0;
    armed   = 0;
    lastExp = 64'd0;
    rst     = 1'b1;
    start   = 1'b1;
    sgn     = 1'b0;
    a       = 32'hFFFF_FFFF;
    b       = 32'hFFFF_FFFF;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_no_start", 64'(busy), 64'd0);
    armed = 1;

    $display("[TB] directed vectors");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    waitIdle(60);
    applyStimulus(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    waitIdle(60);
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    waitIdle(60);
    applyStimulus(1'b0, 32'h0000_0000, 32'h1234_5678, 1'b1, 64'd0);
    waitIdle(60);

    $display("[TB] handshake");
    applyStimulus(1'b0, 32'd7, 32'd6, 1'b1, 64'd42);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    checkOutput("done_cycle_start_hi", 64'(done), 64'd1);
    applyStimulus(1'b0, 32'd2, 32'd3, 1'b1, 64'd6);
    checkOutput("done_falls_on_accept", 64'(done), 64'd0);
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    waitIdle(60);

    $display("[TB] abort");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    qExp.delete();
    @(posedge clk); #1;
    rst     = 1'b0;
    lastExp = 64'd0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      applyStimulus(s, pickOperand(), pickOperand(), 1'b0, 64'd0);
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(1, 20);
        repeat (j - 1) @(posedge clk);
        #1;
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (33 - j) @(posedge clk);
      end else begin
        repeat (33) @(posedge clk);
      end
      #1;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    waitIdle(80);
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult32_seq.md
MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  rising-edge clock; all state changes on its rising edge.
REQ-003 RST  input  1  synchronous active-high reset; sampled on CLK rising edge.
REQ-004 START  input  1  request to begin a multiply; sampled on CLK rising edge.
REQ-005 SGN  input  1  operand mode, sampled with START: 0 = unsigned, 1 = two's complement.
REQ-006 A  input  32  multiplicand, captured on the accepting edge.
REQ-007 B  input  32  multiplier, captured on the accepting edge.
REQ-008 HI  output  32  registered upper 32 bits of the 64-bit product.
REQ-009 LO  output  32  registered lower 32 bits of the 64-bit product.
REQ-010 BUSY  output  1  registered; high while a multiply is in progress.
REQ-011 DONE  output  1  registered; one-cycle pulse, high when HI/LO hold a newly completed result.

Function
REQ-012 The controller SHALL have three states: IDLE, RUN and FIN; the iteration counter SHALL be 6 bits.
REQ-013 START sampled high in IDLE (edge E0) SHALL:
- capture A, B and SGN;
- for SGN=1, capture operand magnitudes and record the result sign as the XOR of the operand MSBs;
- clear the 64-bit accumulator and counter;
- enter RUN.
REQ-014 Each RUN edge SHALL perform one shift-add iteration: if multiplier LSB=1, add multiplicand to the accumulator upper half; then shift the accumulator and multiplier right by 1; increment the counter.
REQ-015 After the 32nd RUN iteration (edge E0+32), the block SHALL enter FIN.
REQ-016 At the FIN edge (E0+33), the block SHALL:
- load HI/LO with the product, two's-complement negated across all 64 bits if the result sign is 1;
- set DONE=1;
- return to IDLE.
REQ-017 DONE SHALL be high only in the single cycle after edge E0+33; total latency SHALL be 33 edges from accept to DONE.
REQ-018 BUSY SHALL be 1 exactly while in RUN or FIN, i.e. from edge E0 until edge E0+33.
REQ-019 START while BUSY=1 SHALL be ignored; operand changes after E0 SHALL NOT affect the result.
REQ-020 START high in the DONE cycle SHALL be accepted (state is IDLE); DONE SHALL fall on that same edge.
REQ-021 HI/LO SHALL hold their value from completion until the next completion or reset; they SHALL NOT change during RUN.
REQ-022 The product SHALL be exact across the full 64 bits with no overflow, including -2^31 x -2^31 = 2^62.
REQ-023 Zero operands SHALL still take the full 33-edge latency (no early termination).

Reset
REQ-024 RST=1 SHALL force state=IDLE, counter=0, accumulator=0, HI=0, LO=0, BUSY=0, DONE=0 on the next edge.
REQ-025 RST SHALL take priority over START and over any in-flight operation; an aborted multiply SHALL produce no DONE.

Verification
REQ-026 Reset: assert RST 2 cycles with START=1 -> HI=LO=0x00000000, BUSY=0, DONE=0, and no operation starts.
REQ-027 Unsigned: SGN=0, A=B=0xFFFFFFFF -> DONE in the cycle after E0+33; HI=0xFFFFFFFE, LO=0x00000001; BUSY high for exactly 33 cycles.
REQ-028 Signed: SGN=1, A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-029 Signed corner: SGN=1, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-030 Handshake: A=7, B=6 started; at E0+10 pulse START with A=9 -> ignored, HI=0, LO=42. Then START in the DONE cycle with A=2, B=3 -> accepted, LO=6 after 33 more edges.
REQ-031 Abort: RST at E0+10 of A=B=0xFFFFFFFF -> next edge IDLE, BUSY=0, HI=LO=0, and no DONE for 40 cycles.
